// File: rtl/player_input_encoder.sv
// Per-player key encoder: synchronises and debounces raw board keys, then turns
// them into a spaced command stream (direction + bomb) with auto-repeat.
module player_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 6,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic       i_key_left,
  input  logic       i_key_right,
  input  logic       i_key_bomb,
  output logic [2:0] o_direction,
  output logic       o_bomb,
  output logic       o_valid
);

  localparam logic [2:0]       DIR_STOP = 3'd4;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t           state, state_n;
  logic [4:0]       raw_keys;
  logic [4:0]       key_p0, key_p1, stable;
  logic [CNT_W-1:0] db_cnt [5];
  logic [2:0]       dir, last_dir;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_n;
  logic             bomb_prev, bomb_pend, def_pend;
  logic             dir_req, bomb_req, emit;

  // bit order: 0=up 1=down 2=left 3=right 4=bomb
  assign raw_keys = {i_key_bomb, i_key_right, i_key_left, i_key_down, i_key_up};

  // p0/p1: two-flop synchroniser, then per-key debounce into stable
  always_ff @(posedge clk) begin
    if (rst) begin
      key_p0 <= '0;
      key_p1 <= '0;
      stable <= '0;
      for (int k = 0; k < 5; k++) db_cnt[k] <= '0;
    end else begin
      key_p0 <= raw_keys;
      key_p1 <= key_p0;
      for (int k = 0; k < 5; k++) begin
        if (key_p1[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] >= DB_LAST) begin
          stable[k] <= ~stable[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    dir = DIR_STOP;
    if      (stable[0]) dir = 3'd0;
    else if (stable[1]) dir = 3'd1;
    else if (stable[2]) dir = 3'd2;
    else if (stable[3]) dir = 3'd3;
  end

  always_comb begin
    state_n   = state;
    rpt_cnt_n = rpt_cnt;
    dir_req   = 1'b0;
    case (state)
      IDLE: begin
        if (dir != DIR_STOP) begin
          dir_req   = 1'b1;
          state_n   = DELAY;
          rpt_cnt_n = '0;
        end
      end
      DELAY, REPEAT: begin
        if (dir == DIR_STOP) begin
          state_n   = IDLE;
          rpt_cnt_n = '0;
        end else if (dir != last_dir) begin
          dir_req   = 1'b1;
          state_n   = DELAY;
          rpt_cnt_n = '0;
        end else if (rpt_cnt >= ((state == DELAY) ? RD_LAST : RP_LAST)) begin
          dir_req   = 1'b1;
          state_n   = REPEAT;
          rpt_cnt_n = '0;
        end else begin
          rpt_cnt_n = rpt_cnt + CNT_ONE;
        end
      end
      default: begin
        state_n   = IDLE;
        rpt_cnt_n = '0;
      end
    endcase
  end

  // A request landing on a strobe cycle waits one cycle; the pending flags merge it
  assign bomb_req = bomb_pend | (stable[4] & ~bomb_prev);
  assign emit     = ~o_valid & (dir_req | (def_pend & (dir != DIR_STOP)) | bomb_req);

  // command register stage: fields held for the strobe cycle and the one after
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rpt_cnt     <= '0;
      last_dir    <= DIR_STOP;
      bomb_prev   <= 1'b0;
      bomb_pend   <= 1'b0;
      def_pend    <= 1'b0;
      o_valid     <= 1'b0;
      o_direction <= DIR_STOP;
      o_bomb      <= 1'b0;
    end else begin
      state     <= state_n;
      rpt_cnt   <= rpt_cnt_n;
      last_dir  <= dir;
      bomb_prev <= stable[4];
      bomb_pend <= bomb_req & ~emit;
      def_pend  <= (dir_req | def_pend) & ~emit & (dir != DIR_STOP);
      o_valid   <= emit;
      if (emit) begin
        o_direction <= dir;
        o_bomb      <= bomb_req;
      end else if (!o_valid) begin
        o_direction <= DIR_STOP;
        o_bomb      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_player_input_encoder.sv
// Directed bench for player_input_encoder: stimulus pushes expected strobes into
// a queue, a negedge monitor pops and checks every strobe and its window.
module tb_player_input_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_bomb = 1'b0;
  logic [2:0] direction;
  logic       bomb, valid;

  player_input_encoder #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(6), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst),
    .i_key_up(key_up), .i_key_down(key_down), .i_key_left(key_left),
    .i_key_right(key_right), .i_key_bomb(key_bomb),
    .o_direction(direction), .o_bomb(bomb), .o_valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] dir;
    logic       bmb;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_strobe(input int c, input logic [2:0] d, input logic b);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    e.bmb = b;
    exp_q.push_back(e);
  endtask

  // Monitor: checks strobes against the queue, the second window cycle, and idle outputs
  exp_t cur;
  bit   prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        chk("no_back_to_back", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe_cycle", cyc, -1);
          cur.dir = direction;
          cur.bmb = bomb;
        end else begin
          cur = exp_q.pop_front();
          chk("strobe_cycle", cyc, cur.cyc);
          chk("strobe_dir", int'(direction), int'(cur.dir));
          chk("strobe_bomb", int'(bomb), int'(cur.bmb));
        end
      end else if (prev_valid) begin
        chk("window_dir", int'(direction), int'(cur.dir));
        chk("window_bomb", int'(bomb), int'(cur.bmb));
      end else begin
        chk("idle_outputs", int'({direction, bomb}), int'({3'd4, 1'b0}));
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  int b;

  initial begin
    // reset state
    at(2);
    @(negedge clk);
    chk("reset_dir", int'(direction), 4);
    chk("reset_bomb", int'(bomb), 0);
    chk("reset_valid", int'(valid), 0);
    at(3);
    rst = 1'b0;
    mon_en = 1'b1;

    // short UP glitch: filtered out
    b = 10;
    at(b);     key_up = 1'b1;
    at(b + 3); key_up = 1'b0;

    // LEFT held: first press, delay, repeats, quiet after release
    b = 30;
    expect_strobe(b + 7, 3'd2, 1'b0);
    expect_strobe(b + 17, 3'd2, 1'b0);
    expect_strobe(b + 23, 3'd2, 1'b0);
    expect_strobe(b + 29, 3'd2, 1'b0);
    expect_strobe(b + 35, 3'd2, 1'b0);
    at(b);      key_left = 1'b1;
    at(b + 34); key_left = 1'b0;

    // bomb held: one strobe only
    b = 100;
    expect_strobe(b + 7, 3'd4, 1'b1);
    at(b);      key_bomb = 1'b1;
    at(b + 20); key_bomb = 1'b0;

    // UP+RIGHT: UP wins, then RIGHT takes over after UP release
    b = 150;
    expect_strobe(b + 7, 3'd0, 1'b0);
    expect_strobe(b + 17, 3'd0, 1'b0);
    expect_strobe(b + 23, 3'd0, 1'b0);
    expect_strobe(b + 29, 3'd0, 1'b0);
    expect_strobe(b + 35, 3'd0, 1'b0);
    expect_strobe(b + 37, 3'd3, 1'b0);
    expect_strobe(b + 47, 3'd3, 1'b0);
    expect_strobe(b + 53, 3'd3, 1'b0);
    at(b);      key_up = 1'b1; key_right = 1'b1;
    at(b + 30); key_up = 1'b0;
    at(b + 50); key_right = 1'b0;

    // bomb debounced during a LEFT strobe: deferred and merged
    b = 230;
    expect_strobe(b + 7, 3'd2, 1'b0);
    expect_strobe(b + 9, 3'd2, 1'b1);
    at(b);      key_left = 1'b1;
    at(b + 1);  key_bomb = 1'b1;
    at(b + 10); key_left = 1'b0;
    at(b + 12); key_bomb = 1'b0;

    // reset while DOWN held in REPEAT, DOWN re-detected afterwards
    b = 280;
    expect_strobe(b + 7, 3'd1, 1'b0);
    expect_strobe(b + 17, 3'd1, 1'b0);
    expect_strobe(b + 23, 3'd1, 1'b0);
    at(b);      key_down = 1'b1;
    at(b + 26); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_dir", int'(direction), 4);
    chk("rst_mid_bomb", int'(bomb), 0);
    chk("rst_mid_valid", int'(valid), 0);
    expect_strobe(b + 35, 3'd1, 1'b0);
    expect_strobe(b + 45, 3'd1, 1'b0);
    at(b + 28); rst = 1'b0;
    at(b + 40); key_down = 1'b0;

    at(b + 70);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
